// File: rtl/cache_backing_memory.sv
// Main-memory responder behind the two-way cache: one request at a time, fixed latency,
// single-cycle completion pulse, and saturating read/write access counters.
`timescale 1ns/1ps
module cache_backing_memory #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemReq,
    input  logic              MemRWB,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemWData,
    output logic [DATA_W-1:0] MemRData,
    output logic              MemReady,
    output logic              MemBusy,
    output logic [7:0]        ReadCount,
    output logic [7:0]        WriteCount
);

    localparam int         DEPTH    = 2**ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rwb_q, rwb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          rd_cnt_q, rd_cnt_d;
    logic [7:0]          wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                accept;
    logic                respond_en;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State register and control/status flops
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= '0;
            rd_cnt_q <= 8'd0;
            wr_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Request capture needs no reset: it is only consumed after an accept
    always_ff @(posedge Clk) begin
        rwb_q   <= rwb_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Reset restores the identity pattern Mem[a] = a
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (respond_en && !rwb_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MemReq) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept     = (state_q == S_IDLE) && MemReq;
        respond_en = (state_q == S_WAIT) && (cnt_q == 4'd0);
        rwb_d      = accept ? MemRWB   : rwb_q;
        addr_d     = accept ? MemAddr  : addr_q;
        wdata_d    = accept ? MemWData : wdata_q;
        rdata_d    = rdata_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (respond_en) begin
            if (rwb_q) begin
                rdata_d  = mem_q[addr_q];
                rd_cnt_d = sat_inc(rd_cnt_q);
            end else begin
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
        end
    end

    // Outputs decode from registered state only
    always_comb begin
        MemReady   = (state_q == S_RESPOND);
        MemBusy    = (state_q != S_IDLE);
        MemRData   = rdata_q;
        ReadCount  = rd_cnt_q;
        WriteCount = wr_cnt_q;
    end

endmodule
